// File: rtl/muldiv_pkg.sv
// Shared types and opcode constants for the IEU multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quotient_o/remainder_o show the values after the step taken in the current cycle.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CW   = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [CW-1:0]   n_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [CW-1:0]   shamt;

  // Narrow (word) divisions pre-align the dividend so its top N bits are consumed first.
  assign shamt = CW'(XLEN) - n_i;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    rem_step = shifted[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;
  assign last_o      = (cnt_q == CW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i << shamt;
      dsr_q <= divisor_i;
      cnt_q <= n_i;
    end else if (cnt_q != '0) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ieu_muldiv.sv
// Multi-cycle RISC-V M-extension unit: single-cycle multiply, iterative divide,
// Start/Busy/Done handshake with synchronous Flush.
module ieu_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit WORD_OPS = (XLEN == 64)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("ieu_muldiv: XLEN must be 32 or 64");
    end
  endgenerate

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return XLEN'($signed(x[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return XLEN'(x[31:0]);
  endfunction

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] x, input logic w);
    return w ? sext32(x) : x;
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      funct3_q;
  logic            word_q, q_neg_q, r_neg_q;

  // Start-cycle operand decode
  logic            word_in, div_signed_in, is_rem_in, accept;
  logic [XLEN-1:0] a_ext_in, b_ext_in, a_mag_in, b_mag_in, min_neg, special_res;
  logic            a_neg_in, b_neg_in, b_zero_in, ovf_in;
  logic [CW-1:0]   n_in;

  assign word_in       = word_op_i & WORD_OPS;
  assign div_signed_in = ~funct3_i[0];
  assign is_rem_in     = funct3_i[1];
  assign accept        = (state_q == ST_IDLE) && start_i && !flush_i;

  assign a_ext_in = word_in ? (div_signed_in ? sext32(src_a_i) : zext32(src_a_i)) : src_a_i;
  assign b_ext_in = word_in ? (div_signed_in ? sext32(src_b_i) : zext32(src_b_i)) : src_b_i;
  assign a_neg_in = div_signed_in & a_ext_in[XLEN-1];
  assign b_neg_in = div_signed_in & b_ext_in[XLEN-1];
  assign a_mag_in = a_neg_in ? -a_ext_in : a_ext_in;
  assign b_mag_in = b_neg_in ? -b_ext_in : b_ext_in;
  assign n_in     = word_in ? CW'(32) : CW'(XLEN);

  // Most-negative value of the active width, already sign-extended to XLEN.
  assign min_neg   = {XLEN{1'b1}} << (word_in ? 31 : XLEN - 1);
  assign b_zero_in = (b_ext_in == '0);
  assign ovf_in    = div_signed_in && (a_ext_in == min_neg) && (b_ext_in == '1);

  always_comb begin
    special_res = '0;
    if (b_zero_in) special_res = is_rem_in ? a_ext_in : '1;
    else           special_res = is_rem_in ? '0 : a_ext_in;
    special_res = word_fix(special_res, word_in);
  end

  // Multiplier: both operands sign/zero-extended to 2*XLEN; the wrapped product is exact.
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0] mul_res;

  assign a_sgn   = (funct3_q == F3_MULH) || (funct3_q == F3_MULHSU);
  assign b_sgn   = (funct3_q == F3_MULH);
  assign a_w     = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
  assign b_w     = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
  assign prod    = a_w * b_w;
  assign mul_res = (funct3_q == F3_MUL) ? word_fix(prod[XLEN-1:0], word_q)
                                        : prod[2*XLEN-1:XLEN];

  logic            div_load, div_last;
  logic [XLEN-1:0] div_quo, div_rem, div_res;

  muldiv_divider #(.XLEN(XLEN), .CW(CW)) u_divider (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (div_load),
    .divisor_i   (b_mag_in),
    .dividend_i  (a_mag_in),
    .n_i         (n_in),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  assign div_res = word_fix(funct3_q[1] ? (r_neg_q ? -div_rem : div_rem)
                                        : (q_neg_q ? -div_quo : div_quo), word_q);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    div_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (!funct3_i[2]) begin
            state_d = ST_MUL;
          end else if (b_zero_in || ovf_in) begin
            state_d  = ST_DONE;
            result_d = special_res;
          end else begin
            state_d  = ST_DIV;
            div_load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        state_d  = ST_DONE;
        result_d = mul_res;
      end
      ST_DIV: begin
        if (div_last) begin
          state_d  = ST_DONE;
          result_d = div_res;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      div_load = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      funct3_q <= '0;
      word_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        a_q      <= src_a_i;
        b_q      <= src_b_i;
        funct3_q <= funct3_i;
        word_q   <= word_in;
        q_neg_q  <= a_neg_in ^ b_neg_in;
        r_neg_q  <= a_neg_in;
      end
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ieu_muldiv.sv
// Scoreboard bench for ieu_muldiv: XLEN=32 and XLEN=64 instances driven with directed vectors.
module tb_ieu_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start32, flush32, wop32, busy32, done32;
  logic [2:0]  f3_32;
  logic [31:0] a32, b32, res32;
  logic        start64, flush64, wop64, busy64, done64;
  logic [2:0]  f3_64;
  logic [63:0] a64, b64, res64;

  ieu_muldiv #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .flush_i(flush32),
    .funct3_i(f3_32), .word_op_i(wop32), .src_a_i(a32), .src_b_i(b32),
    .busy_o(busy32), .done_o(done32), .result_o(res32)
  );

  ieu_muldiv #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start64), .flush_i(flush64),
    .funct3_i(f3_64), .word_op_i(wop64), .src_a_i(a64), .src_b_i(b64),
    .busy_o(busy64), .done_o(done64), .result_o(res64)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last32 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_unexpected: got Done with result 0x%0h, expected no Done", res32);
      end else begin
        e = q32.pop_front();
        check("result32", 64'(res32), e.res);
        check("done_cycle32", 64'(cyc), 64'(e.cyc));
        $display("txn dut32 cycle=%0d result=0x%08h", cyc, res32);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (done64) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done64_unexpected: got Done with result 0x%0h, expected no Done", res64);
      end else begin
        e = q64.pop_front();
        check("result64", res64, e.res);
        check("done_cycle64", 64'(cyc), 64'(e.cyc));
        $display("txn dut64 cycle=%0d result=0x%016h", cyc, res64);
      end
    end
  end

  task automatic launch(input bit d64, input logic [2:0] f3, input bit w,
                        input logic [63:0] a, input logic [63:0] b);
    if (d64) begin
      start64 = 1'b1; f3_64 = f3; wop64 = w; a64 = a; b64 = b;
    end else begin
      start32 = 1'b1; f3_32 = f3; wop32 = w; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic release_start();
    start32 = 1'b0;
    start64 = 1'b0;
  endtask

  // Counts busy cycles from c+1; a stuck Busy ends at the bound and fails the count.
  task automatic wait_idle(input bit d64, input int lat, input string name);
    int cnt = 0;
    while ((d64 ? busy64 : busy32) && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(lat));
  endtask

  task automatic issue(input bit d64, input logic [2:0] f3, input bit w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] expv, input int lat, input string name);
    exp_t e;
    @(posedge clk); #1;
    launch(d64, f3, w, a, b);
    e.res = expv;
    e.cyc = cyc + lat;
    if (d64) q64.push_back(e);
    else begin
      q32.push_back(e);
      last32 = expv[31:0];
    end
    @(posedge clk); #1;
    release_start();
    wait_idle(d64, lat, name);
  endtask

  initial begin
    exp_t e;
    int   c;
    rst_n = 1'b0;
    start32 = 0; flush32 = 0; wop32 = 0; f3_32 = '0; a32 = '0; b32 = '0;
    start64 = 0; flush64 = 0; wop64 = 0; f3_64 = '0; a64 = '0; b64 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy32", 64'(busy32), 64'(0));
    check("rst_done32", 64'(done32), 64'(0));
    check("rst_result32", 64'(res32), 64'(0));
    check("rst_busy64", 64'(busy64), 64'(0));
    check("rst_result64", res64, 64'(0));
    rst_n = 1'b1;

    // XLEN=32 multiplies
    issue(0, F3_MULH,   0, 64'h80000000, 64'h80000000, 64'h40000000, 2, "mulh");
    issue(0, F3_MULHSU, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2, "mulhsu");
    issue(0, F3_MULHU,  0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2, "mulhu");
    issue(0, F3_MUL,    0, 64'h12345678, 64'h00000010, 64'h23456780, 2, "mul");
    issue(0, F3_MUL,    0, 64'h00000007, 64'hFFFFFFFD, 64'hFFFFFFEB, 2, "mul_neg");
    // XLEN=32 divides
    issue(0, F3_DIV,  0, 64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFD, 33, "div");
    issue(0, F3_REM,  0, 64'h00000007, 64'hFFFFFFFE, 64'h00000001, 33, "rem_pos_neg");
    issue(0, F3_DIVU, 0, 64'hFFFFFFFF, 64'h00000001, 64'hFFFFFFFF, 33, "divu_max");
    issue(0, F3_REMU, 0, 64'd100,      64'd7,        64'd2,        33, "remu");
    issue(0, F3_DIVU, 0, 64'h00001234, 64'h0,        64'hFFFFFFFF, 1,  "divu_by0");
    issue(0, F3_REMU, 0, 64'h00001234, 64'h0,        64'h00001234, 1,  "remu_by0");
    issue(0, F3_REM,  0, 64'hFFFFFFFB, 64'h0,        64'hFFFFFFFB, 1,  "rem_by0");
    issue(0, F3_DIV,  0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1,  "div_ovf");
    issue(0, F3_REM,  0, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1,  "rem_ovf");
    issue(0, F3_REM,  0, 64'hFFFFFFF9, 64'h00000002, 64'hFFFFFFFF, 33, "rem");

    // XLEN=64 word and full-width ops
    issue(1, F3_DIV,   1, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_80000000, 1, "divw_ovf");
    issue(1, F3_DIVU,  1, 64'd100, 64'd7, 64'd14, 33, "divuw");
    issue(1, F3_DIVU,  1, 64'h00000000_FFFFFFFE, 64'd1, 64'hFFFFFFFF_FFFFFFFE, 33, "divuw_sext");
    issue(1, F3_REM,   1, 64'h12345678_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFF, 33, "remw");
    issue(1, F3_DIVU,  1, 64'd100, 64'h00000005_00000000, 64'hFFFFFFFF_FFFFFFFF, 1, "divuw_by0");
    issue(1, F3_MUL,   1, 64'h00000000_7FFFFFFF, 64'd2, 64'hFFFFFFFF_FFFFFFFE, 2, "mulw");
    issue(1, F3_MULHU, 0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 2, "mulhu64");
    issue(1, F3_DIV,   0, 64'hFFFFFFFF_FFFFFF9C, 64'd7, 64'hFFFFFFFF_FFFFFFF2, 65, "div64");

    // Flush mid-divide, then a Start in the very next cycle
    @(posedge clk); #1;
    launch(0, F3_DIV, 0, 64'd100, 64'd7);
    c = cyc;
    @(posedge clk); #1;
    release_start();
    repeat (9) @(posedge clk);
    #1;
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    check("flush_busy", 64'(busy32), 64'(0));
    check("flush_cycle", 64'(cyc), 64'(c + 11));
    check("flush_result_hold", 64'(res32), 64'(last32));
    launch(0, F3_DIVU, 0, 64'd100, 64'd7);
    e.res = 64'd14;
    e.cyc = cyc + 33;
    q32.push_back(e);
    last32 = 32'd14;
    @(posedge clk); #1;
    release_start();
    wait_idle(0, 33, "after_flush");

    // Flush together with Start in IDLE: nothing starts
    @(posedge clk); #1;
    launch(0, F3_MUL, 0, 64'd3, 64'd3);
    flush32 = 1'b1;
    @(posedge clk); #1;
    release_start();
    flush32 = 1'b0;
    check("flush_start_busy", 64'(busy32), 64'(0));

    // Asynchronous reset mid-divide
    @(posedge clk); #1;
    launch(0, F3_DIV, 0, 64'd100, 64'd7);
    @(posedge clk); #1;
    release_start();
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy32), 64'(1));
    rst_n = 1'b0;
    #1;
    check("areset_busy", 64'(busy32), 64'(0));
    check("areset_done", 64'(done32), 64'(0));
    check("areset_result", 64'(res32), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    issue(0, F3_MULHU, 0, 64'h00010000, 64'h00010000, 64'h00000001, 2, "post_reset");

    repeat (5) @(posedge clk);
    #1;
    check("q32_drained", 64'(q32.size()), 64'(0));
    check("q64_drained", 64'(q64.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ieu_muldiv.md
Name: ieu_muldiv

Overview:
- Parametrised multi-cycle integer multiply/divide unit implementing the RISC-V M extension (plus RV64M word ops when XLEN=64).
- Sits beside the ALU inside the IEU.
- The IEU raises Start for an M-type instruction, stalls on Busy, and writes Result to the register file on the Done cycle.
- Successor to the single-cycle-only IEU datapath: adds XLEN generalisation, iterative division and a stall/flush handshake.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
WORD_OPS, (XLEN==64), enables the WordOp port behaviour; when 0, WordOp is ignored.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
Start  input  1  request a new operation; sampled only in IDLE.
Flush  input  1  synchronous abort of any operation in progress.
Funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
WordOp  input  1  W-variant: 32-bit operation, result sign-extended to XLEN.
SrcA  input  XLEN  rs1 operand (dividend / multiplicand).
SrcB  input  XLEN  rs2 operand (divisor / multiplier).
Busy  output  1  high whenever state != IDLE; the IEU stalls on it.
Done  output  1  single-cycle pulse; Result is valid in this cycle.
Result  output  XLEN  registered result; holds its value until the next Done.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, Busy=0, Done=0, Result=0, all internal registers cleared. Reset mid-operation abandons the operation; there is no Done.
- States: IDLE, MUL, DIV, DONE.
- IDLE, Start=1, Flush=0: operands, Funct3 and WordOp are latched; Start is ignored in every other state.
  - Funct3[2]=0 -> MUL.
  - Funct3[2]=1 with divisor zero or signed overflow -> DONE directly (special case).
  - Funct3[2]=1 otherwise -> DIV, with count=N, where N=32 if (WordOp & WORD_OPS) else XLEN.
- MUL: one cycle.
  - Forms the full 2*XLEN product of the operands, each extended according to Funct3: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Word MULW: low 32 bits, sign-extended.
  - Next state DONE.
- DIV: radix-2 restoring shift-subtract on operand magnitudes, one quotient bit per cycle.
  - count decrements each cycle; at count==1 -> DONE.
  - Signed ops: quotient negated if operand signs differ; remainder takes the sign of the dividend.
- Word ops: operands are the low 32 bits, sign- or zero-extended per signedness; the 32-bit result is sign-extended to XLEN.
- Special cases (RISC-V mandated):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1, width per WordOp): quotient = dividend, remainder = 0.
- DONE: Done=1 and Result valid for exactly one cycle; next state IDLE. Busy=1 in DONE.
- Latency, counted from the Start cycle c:
  - MUL: Done at c+2.
  - Special-case divide: Done at c+1.
  - Normal divide: Done at c+N+1 (c+33 for XLEN=32).
- Flush=1 in any state: next state IDLE, no Done, Result unchanged. Flush together with Start in IDLE: Flush wins and the operation is not started.
- Back-to-back: a Start in the cycle after Done, when the unit is back in IDLE, is accepted.

Decomposition:
- Package muldiv_pkg:
  - state enum (IDLE, MUL, DIV, DONE);
  - Funct3 localparams (F3_MUL ... F3_REMU);
  - XLEN legality check.
- Sub-module muldiv_divider: iterative magnitude divider core.
  - Inputs: load, divisor, dividend, N.
  - Outputs: quotient, remainder, last.
  - Sign handling and special cases stay in ieu_muldiv.

Test Plan:
- XLEN=32, MULH SrcA=SrcB=0x80000000 -> Done at c+2, Result=0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 0x00000002 -> Done at c+33, Result=0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. Busy high c+1..c+33.
- DIVU 0x00001234 / 0 -> Done at c+1, Result=0xFFFFFFFF. REMU -> 0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0.
- Flush at c+10 during DIV -> Busy=0 at c+11, no Done pulse, Result unchanged; Start at c+11 is accepted normally.
- reset driven low at c+5 of DIV, asynchronously -> Busy=0, Done=0, Result=0 before the next edge; no later Done.
- XLEN=64, DIVW WordOp=1 SrcA=0x00000000_80000000, SrcB=0xFFFFFFFF_FFFFFFFF -> special case, Done at c+1, Result=0xFFFFFFFF_80000000. DIVUW 100/7 -> Done at c+33, Result=14.
